switch_debouncer: RTL and testbench

//  Upstream conditioning stage for the board slide switches: synchronises each raw

---
 rtl/switch_pkg.sv | 8 +
 rtl/debounce_bit.sv | 35 +++
 rtl/switch_debouncer.sv | 30 +++
 tb/tb_switch_debouncer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared switch-bank constants and the per-bit debounce state type.
package switch_pkg;
  localparam int SW_WIDTH = 16;
  localparam int CLK_HZ = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
  typedef enum logic {STABLE, PENDING} db_state_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one switch bit: 2-flop synchroniser, stability counter and debounced level flop.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic changed,
  output logic toggle
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, db_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  db_state_t state;
  // state is implied by sync2 vs db, so no separate state register is kept
  always_comb begin
    state = (sync2 != db) ? PENDING : STABLE;
    toggle = (state == PENDING) && (cnt == LAST);
    cnt_next = (state == STABLE || toggle) ? '0 : cnt + 1'b1;
    db_next = toggle ? sync2 : db;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1, sync2, cnt, db, changed} <= '0;
    else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt <= cnt_next;
      db <= db_next;
      changed <= toggle;
    end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: WIDTH independent debounced switch bits plus change-pulse reporting.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] changed_mask,
  output logic             sw_changed
);
  logic [WIDTH-1:0] toggle;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk(clk),
      .rst_n(rst_n),
      .raw(sw_raw[i]),
      .db(sw_db[i]),
      .changed(changed_mask[i]),
      .toggle(toggle[i])
    );
  end
  // registered from the unregistered toggles so it lines up with changed_mask
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sw_changed <= 1'b0;
    else sw_changed <= |toggle;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed vector table plus randomized bouncing against a history-window model.
module tb_switch_debouncer;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] raw = 16'hFFFF;
  logic [W-1:0] sw_db, changed_mask;
  logic sw_changed;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_db, m_mask, prev_raw;
  logic [W-1:0] s2h[$];

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(raw),
    .sw_db(sw_db), .changed_mask(changed_mask), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic [W-1:0] raw;
    int n;
    logic [W-1:0] db;
    logic [W-1:0] mask;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // sw_db flips a bit when the last N synchronised samples all disagree with it
  task automatic model_edge();
    logic [W-1:0] diff;
    if (!rst_n) begin
      m_db = '0; m_mask = '0; prev_raw = '0;
      s2h = {};
      for (int j = 0; j < N; j++) s2h.push_back('0);
      return;
    end
    diff = '1;
    for (int j = 0; j < N; j++) diff &= s2h[s2h.size() - 1 - j] ^ m_db;
    m_mask = diff;
    m_db ^= diff;
    s2h.push_back(prev_raw);
    if (s2h.size() > N) void'(s2h.pop_front());
    prev_raw = raw;
  endtask

  task automatic edge_chk();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_db", sw_db, m_db);
    chk("model_mask", changed_mask, m_mask);
    chk("model_chg", {15'd0, sw_changed}, {15'd0, |m_mask});
  endtask

  task automatic drive(input logic r, input logic [W-1:0] v);
    rst_n = r;
    raw = v;
    if (!r) model_edge();
  endtask

  initial begin
    model_edge();
    #1;
    chk("reset_db", sw_db, 16'h0000);
    chk("reset_mask", changed_mask, 16'h0000);
    chk("reset_chg", {15'd0, sw_changed}, 16'h0000);
    tbl = '{
      '{1'b0, 16'hFFFF, 2, 16'h0000, 16'h0000},
      '{1'b1, 16'hFFFF, 5, 16'h0000, 16'h0000},
      '{1'b1, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF},
      '{1'b1, 16'hFFFF, 2, 16'hFFFF, 16'h0000},
      '{1'b0, 16'h0000, 2, 16'h0000, 16'h0000},
      '{1'b1, 16'h0000, 2, 16'h0000, 16'h0000},
      '{1'b1, 16'h0001, 5, 16'h0000, 16'h0000},
      '{1'b1, 16'h0001, 1, 16'h0001, 16'h0001},
      '{1'b1, 16'h0001, 2, 16'h0001, 16'h0000},
      '{1'b1, 16'h0009, 1, 16'h0001, 16'h0000},
      '{1'b1, 16'h0001, 1, 16'h0001, 16'h0000},
      '{1'b1, 16'h0009, 1, 16'h0001, 16'h0000},
      '{1'b1, 16'h0001, 1, 16'h0001, 16'h0000},
      '{1'b1, 16'h0009, 5, 16'h0001, 16'h0000},
      '{1'b1, 16'h0009, 1, 16'h0009, 16'h0008},
      '{1'b1, 16'h0009, 2, 16'h0009, 16'h0000},
      '{1'b1, 16'h0089, 3, 16'h0009, 16'h0000},
      '{1'b1, 16'h0009, 8, 16'h0009, 16'h0000},
      '{1'b1, 16'h8008, 5, 16'h0009, 16'h0000},
      '{1'b1, 16'h8008, 1, 16'h8008, 16'h8001},
      '{1'b1, 16'h8008, 2, 16'h8008, 16'h0000},
      '{1'b1, 16'h800C, 3, 16'h8008, 16'h0000},
      '{1'b0, 16'h800C, 2, 16'h0000, 16'h0000},
      '{1'b1, 16'h800C, 5, 16'h0000, 16'h0000},
      '{1'b1, 16'h800C, 1, 16'h800C, 16'h800C},
      '{1'b1, 16'h800C, 2, 16'h800C, 16'h0000}
    };
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst_n, tbl[k].raw);
      for (int e = 0; e < tbl[k].n; e++) begin
        edge_chk();
        chk($sformatf("vec%0d_db", k), sw_db, tbl[k].db);
        chk($sformatf("vec%0d_mask", k), changed_mask, tbl[k].mask);
        chk($sformatf("vec%0d_chg", k), {15'd0, sw_changed}, {15'd0, |tbl[k].mask});
      end
    end
    // random bouncing: each bit flips with probability 1/8 per cycle, rare resets
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] flips;
      flips = '0;
      for (int b = 0; b < W; b++) flips[b] = ($urandom_range(7) == 0);
      drive($urandom_range(399) != 0, raw ^ flips);
      edge_chk();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
